// File: rtl/esc_pwm_generator_pkg.sv
// rtl/esc_pwm_generator_pkg.sv - shared defines, state encodings and pulse helpers (ESC_ARM_DELAY_EN adds the arming state)
`ifndef COMMON_DEFINES_V
`define COMMON_DEFINES_V
`define REC_VAL_BIT_WIDTH 8
`define TRUE 1'b1
`define FALSE 1'b0
`define BYTE_ALL_ZERO 8'h00
`endif

`ifndef ESC_DEFINES_V
`define ESC_DEFINES_V
`define ESC_MIN_PULSE_US 1000
`define ESC_PERIOD_US 20000
`define ESC_MAX_VALUE 250
`endif

package esc_pwm_generator_pkg;

   localparam int unsigned ESC_PERIOD_DEF      = `ESC_PERIOD_US;
   localparam int unsigned ESC_MIN_PULSE_DEF   = `ESC_MIN_PULSE_US;
   localparam int unsigned ESC_MAX_VALUE_DEF   = `ESC_MAX_VALUE;
   localparam int unsigned ESC_PULSE_SCALE_DEF = 4;

   // Pulse states; the pin state follows the frame count alone
   localparam logic [1:0] ST_PULSE_HIGH = 2'd0;
   localparam logic [1:0] ST_PULSE_LOW  = 2'd1;
`ifdef ESC_ARM_DELAY_EN
   localparam logic [1:0] ST_ARMING     = 2'd2;
   localparam int unsigned ESC_ARM_FRAMES_DEF = 50;
`endif

   // Saturate a motor command at the allowed ceiling
   function automatic logic [7:0] clamp_value(input logic [7:0] value, input int unsigned max_value);
      if (32'(value) > max_value) begin
         return 8'(max_value);
      end
      return value;
   endfunction

   // Pulse width in microseconds for a (clamped) command
   function automatic logic [15:0] pulse_width_of(input logic [7:0] value, input int unsigned min_us,
                                                  input int unsigned scale);
      return 16'(min_us + 32'(value) * scale);
   endfunction

endpackage

// File: rtl/esc_pwm_generator_frame_counter.sv
// rtl/esc_pwm_generator_frame_counter.sv - free-running frame counter shared by PWM outputs
module pwm_frame_counter #(
   parameter int unsigned PERIOD = 20000
) (
   input  logic        us_clk,
   input  logic        reset,
   output logic [15:0] count,
   output logic        frame_start,
   output logic        frame_last
);

   logic [15:0] count_q;
   logic [15:0] count_d;

   // Next count: wrap to zero after the last cycle of the frame
   always_comb begin
      count_d = count_q + 16'd1;
      if (count_q == 16'(PERIOD - 1)) begin
         count_d = '0;
      end
   end

   // Count register
   always_ff @(posedge us_clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count       = count_q;
   assign frame_start = (count_q == 16'd0);
   assign frame_last  = (count_q == 16'(PERIOD - 1));

endmodule

// File: rtl/esc_pwm_generator.sv
// rtl/esc_pwm_generator.sv - motor command to ESC servo pulse, applied at frame boundaries (ESC_ARM_DELAY_EN: post-reset arming)
`ifndef REC_VAL_BIT_WIDTH
`define REC_VAL_BIT_WIDTH 8
`endif
`ifndef TRUE
`define TRUE 1'b1
`define FALSE 1'b0
`define BYTE_ALL_ZERO 8'h00
`endif

module esc_pwm_generator
   import esc_pwm_generator_pkg::*;
#(
   parameter int unsigned PERIOD_US    = ESC_PERIOD_DEF,
   parameter int unsigned MIN_PULSE_US = ESC_MIN_PULSE_DEF,
   parameter int unsigned PULSE_SCALE  = ESC_PULSE_SCALE_DEF,
   parameter int unsigned MAX_VALUE    = ESC_MAX_VALUE_DEF
`ifdef ESC_ARM_DELAY_EN
   ,
   parameter int unsigned ARM_FRAMES   = ESC_ARM_FRAMES_DEF
`endif
) (
   input  logic                          us_clk,
   input  logic                          reset,
   input  logic [`REC_VAL_BIT_WIDTH-1:0] motor_value_in,
   input  logic                          start_signal,
   output logic                          pwm_out,
   output logic                          active_signal,
   output logic                          complete_signal,
   output logic [7:0]                    applied_value_out,
   output logic                          frame_start
);

   logic [15:0] count;
   logic        cnt_frame_start;
   logic        frame_last;

   pwm_frame_counter #(
      .PERIOD(PERIOD_US)
   ) u_frame_counter (
      .us_clk     (us_clk),
      .reset      (reset),
      .count      (count),
      .frame_start(cnt_frame_start),
      .frame_last (frame_last)
   );

   logic        start_flag_q, start_flag_d;
   logic [7:0]  pending_value_q, pending_value_d;
   logic        pending_valid_q, pending_valid_d;
   logic [7:0]  applied_value_q, applied_value_d;
   logic [15:0] pulse_width_q, pulse_width_d;
   logic        pwm_out_q, pwm_out_d;
   logic        complete_q, complete_d;
   logic        frame_start_q, frame_start_d;
   logic        capture;
   logic        apply_en;
   logic [1:0]  pulse_state;

`ifdef ESC_ARM_DELAY_EN
   localparam int ARM_CNT_W = (ARM_FRAMES > 1) ? $clog2(ARM_FRAMES) : 1;
   logic                 arming_q, arming_d;
   logic [ARM_CNT_W-1:0] arm_cnt_q, arm_cnt_d;
   logic                 arm_last;
`endif

   // Capture, pending/apply bookkeeping and next pin level
   always_comb begin
      capture      = start_signal && !start_flag_q;
      start_flag_d = start_signal;
      apply_en     = frame_last && pending_valid_q;
`ifdef ESC_ARM_DELAY_EN
      // The last arming frame boundary is also the first normal one
      arm_last  = arming_q && (arm_cnt_q == ARM_CNT_W'(ARM_FRAMES - 1));
      apply_en  = frame_last && pending_valid_q && (!arming_q || arm_last);
      arming_d  = arming_q;
      arm_cnt_d = arm_cnt_q;
      if (arming_q && frame_last) begin
         if (arm_last) begin
            arming_d = `FALSE;
         end else begin
            arm_cnt_d = arm_cnt_q + ARM_CNT_W'(1);
         end
      end
`endif
      pending_value_d = capture ? clamp_value(motor_value_in, MAX_VALUE) : pending_value_q;
      // A capture on the apply cycle keeps the new value pending
      pending_valid_d = pending_valid_q;
      if (apply_en) begin
         pending_valid_d = `FALSE;
      end
      if (capture) begin
         pending_valid_d = `TRUE;
      end
      applied_value_d = apply_en ? pending_value_q : applied_value_q;
      pulse_width_d   = apply_en ? pulse_width_of(pending_value_q, MIN_PULSE_US, PULSE_SCALE)
                                 : pulse_width_q;
      complete_d      = apply_en;
      frame_start_d   = cnt_frame_start;

      pulse_state = (count < pulse_width_q) ? ST_PULSE_HIGH : ST_PULSE_LOW;
`ifdef ESC_ARM_DELAY_EN
      if (arming_q) begin
         pulse_state = ST_ARMING;
      end
`endif
      pwm_out_d = (pulse_state == ST_PULSE_HIGH);
`ifdef ESC_ARM_DELAY_EN
      if (pulse_state == ST_ARMING) begin
         pwm_out_d = (count < 16'(MIN_PULSE_US));
      end
`endif
   end

   // Command path and output registers
   always_ff @(posedge us_clk or posedge reset) begin
      if (reset) begin
         start_flag_q    <= `FALSE;
         pending_value_q <= `BYTE_ALL_ZERO;
         pending_valid_q <= `FALSE;
         applied_value_q <= `BYTE_ALL_ZERO;
         pulse_width_q   <= 16'(MIN_PULSE_US);
         pwm_out_q       <= `FALSE;
         complete_q      <= `FALSE;
         frame_start_q   <= `FALSE;
      end else begin
         start_flag_q    <= start_flag_d;
         pending_value_q <= pending_value_d;
         pending_valid_q <= pending_valid_d;
         applied_value_q <= applied_value_d;
         pulse_width_q   <= pulse_width_d;
         pwm_out_q       <= pwm_out_d;
         complete_q      <= complete_d;
         frame_start_q   <= frame_start_d;
      end
   end

`ifdef ESC_ARM_DELAY_EN
   // Arming phase tracking after reset
   always_ff @(posedge us_clk or posedge reset) begin
      if (reset) begin
         arming_q  <= `TRUE;
         arm_cnt_q <= '0;
      end else begin
         arming_q  <= arming_d;
         arm_cnt_q <= arm_cnt_d;
      end
   end
`endif

   assign pwm_out           = pwm_out_q;
   assign active_signal     = pending_valid_q;
   assign complete_signal   = complete_q;
   assign applied_value_out = applied_value_q;
   assign frame_start       = frame_start_q;

endmodule

// File: tb/tb_esc_pwm_generator.sv
// tb/tb_esc_pwm_generator.sv - self-checking bench for esc_pwm_generator (ESC_ARM_DELAY_EN adds the arming run)
`timescale 1ns/1ps
module tb_esc_pwm_generator;

   localparam int P     = 1200;
   localparam int MINP  = 100;
   localparam int SCALE = 4;
   localparam int MAXV  = 250;
   localparam int ARM   = 3;

   logic       us_clk = 1'b0;
   logic       reset = 1'b1;
   logic       start_signal = 1'b0;
   logic [7:0] motor_value_in = 8'd0;
   logic       pwm_out, active_signal, complete_signal, frame_start;
   logic [7:0] applied_value_out;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int         width;
      logic [7:0] applied;
      int         complete;
   } frame_exp_t;
   frame_exp_t exp_q[$];
   frame_exp_t cur_exp;

   typedef struct {
      int         pos;
      logic [7:0] value;
      logic [7:0] exp_applied;
      int         exp_width;
   } vec_t;
   vec_t vecs[6];

   always #5 us_clk = ~us_clk;

   esc_pwm_generator #(
      .PERIOD_US(P),
      .MIN_PULSE_US(MINP),
      .PULSE_SCALE(SCALE),
      .MAX_VALUE(MAXV)
`ifdef ESC_ARM_DELAY_EN
      ,
      .ARM_FRAMES(ARM)
`endif
   ) dut (
      .us_clk(us_clk),
      .reset(reset),
      .motor_value_in(motor_value_in),
      .start_signal(start_signal),
      .pwm_out(pwm_out),
      .active_signal(active_signal),
      .complete_signal(complete_signal),
      .applied_value_out(applied_value_out),
      .frame_start(frame_start)
   );

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Frame monitor: measures each emitted frame and compares it with the scoreboard
   int         hi_cnt;
   int         cmp_cnt;
   logic [7:0] frame_applied;
   bit         in_frame = 1'b0;

   always @(negedge us_clk) begin
      if (reset) begin
         in_frame = 1'b0;
      end else begin
         if (frame_start) begin
            if (in_frame && exp_q.size() > 0) begin
               cur_exp = exp_q.pop_front();
               check("frame_width", hi_cnt, cur_exp.width);
               check("frame_applied", frame_applied, cur_exp.applied);
               check("frame_complete_count", cmp_cnt, cur_exp.complete);
            end
            in_frame      = 1'b1;
            hi_cnt        = 0;
            cmp_cnt       = 0;
            frame_applied = applied_value_out;
         end
         if (in_frame) begin
            hi_cnt  += int'(pwm_out);
            cmp_cnt += int'(complete_signal);
         end
      end
   end

   task automatic wait_frame_start(input string name);
      int n = 0;
      do begin
         @(negedge us_clk);
         n++;
      end while (!frame_start && n < 2 * P + 4);
      check(name, frame_start, 1);
   endtask

   // Runs one frame from its frame_start cycle; start at pa is held one extra cycle with a junk value
   task automatic run_frame(input int pa, input logic [7:0] va, input int pb, input logic [7:0] vb,
                            input int e_width, input logic [7:0] e_applied,
                            input int e_complete, input int e_active);
      frame_exp_t e;
      e.width    = e_width;
      e.applied  = e_applied;
      e.complete = e_complete;
      exp_q.push_back(e);
      for (int p = 0; p < P; p++) begin
         if (p == pa) begin
            start_signal   = 1'b1;
            motor_value_in = va;
         end else if (pa >= 0 && p == pa + 1) begin
            start_signal   = 1'b1;
            motor_value_in = ~va;
         end else if (p == pb) begin
            start_signal   = 1'b1;
            motor_value_in = vb;
         end else begin
            start_signal   = 1'b0;
            motor_value_in = 8'($urandom);
         end
         if (p == P - 1) begin
            check("complete_at_count0", complete_signal, e_complete);
            check("active_after_boundary", active_signal, e_active);
         end
         @(negedge us_clk);
      end
      check("frame_sync", frame_start, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_pwm"}, pwm_out, 0);
      check({tag, "_active"}, active_signal, 0);
      check({tag, "_complete"}, complete_signal, 0);
      check({tag, "_frame_start"}, frame_start, 0);
      check({tag, "_applied"}, applied_value_out, 0);
   endtask

   int         prev_w;
   logic [7:0] prev_a;

   initial begin
      vecs[0] = '{pos: 300,   value: 8'd125, exp_applied: 8'd125, exp_width: 600};
      vecs[1] = '{pos: 50,    value: 8'd255, exp_applied: 8'd250, exp_width: 1100};
      vecs[2] = '{pos: 900,   value: 8'd0,   exp_applied: 8'd0,   exp_width: 100};
      vecs[3] = '{pos: P - 3, value: 8'd200, exp_applied: 8'd200, exp_width: 900};
      vecs[4] = '{pos: 10,    value: 8'd251, exp_applied: 8'd250, exp_width: 1100};
      vecs[5] = '{pos: 600,   value: 8'd1,   exp_applied: 8'd1,   exp_width: 104};

      repeat (3) @(negedge us_clk);
      check_reset_outputs("reset");
      reset = 1'b0;
      wait_frame_start("first_frame_start");

`ifdef ESC_ARM_DELAY_EN
      run_frame(10, 8'd250, -1, 8'd0, 100, 8'd0, 0, 1);
      run_frame(-1, 8'd0, -1, 8'd0, 100, 8'd0, 0, 1);
      run_frame(-1, 8'd0, -1, 8'd0, 100, 8'd0, 1, 0);
      prev_w = 1100;
      prev_a = 8'd250;
`else
      run_frame(-1, 8'd0, -1, 8'd0, 100, 8'd0, 0, 0);
      run_frame(-1, 8'd0, -1, 8'd0, 100, 8'd0, 0, 0);
      prev_w = 100;
      prev_a = 8'd0;
`endif

      for (int i = 0; i < 6; i++) begin
         run_frame(vecs[i].pos, vecs[i].value, -1, 8'd0, prev_w, prev_a, 1, 0);
         prev_w = vecs[i].exp_width;
         prev_a = vecs[i].exp_applied;
      end

      // Two starts in one frame: the later one wins
      run_frame(100, 8'd40, 700, 8'd200, prev_w, prev_a, 1, 0);
      // Start on the apply cycle: 60 goes live, 100 stays pending
      run_frame(400, 8'd60, P - 2, 8'd100, 900, 8'd200, 1, 1);
      run_frame(-1, 8'd0, -1, 8'd0, 340, 8'd60, 1, 0);
      // Load a 600-cycle pulse, then reset in the middle of it
      run_frame(200, 8'd125, -1, 8'd0, 500, 8'd100, 1, 0);
      repeat (350) @(negedge us_clk);
      check("pwm_before_reset", pwm_out, 1);
      reset = 1'b1;
      #1;
      check_reset_outputs("midpulse_reset");
      repeat (3) @(negedge us_clk);
      reset = 1'b0;
      wait_frame_start("restart_frame_start");
      run_frame(-1, 8'd0, -1, 8'd0, 100, 8'd0, 0, 0);
      wait_frame_start("final_frame_start");
      check("scoreboard_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
